vmem_arbiter: RTL and testbench
===============================

# vmem_arbiter

Single-port video-memory arbiter between the VGA scan-out read path and two pixel writers (keyboard glyph renderer on port 0, UART image loader on port 1). Display reads own the memory while the VGA controller's `valid` is high. Writers are served round-robin during blanking. A starvation counter lets a blocked writer steal one active-display slot when needed. Sits between `vga_ctrl` (`h_addr`/`v_addr`/`valid`) and a synchronous-read frame buffer replacing the combinational `vmem`.

## Interface
- `ADDR_W`, 19, memory address width; the address is `{h_addr[9:0], v_addr[8:0]}`.
- `DATA_W`, 24, pixel width (RGB888).
- `STARVE_LIMIT`, 15, consecutive blocked-writer cycles before a slot steal (1..255).

- `clk`  in  1  pixel clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `vga_valid`  in  1  display active; a read is required this cycle.
- `vga_addr`  in  ADDR_W  pixel address to read.
- `vga_data`  out  DATA_W  registered pixel to the VGA controller.
- `req0_valid` / `req1_valid`  in  1  writer has a pending pixel write.
- `req0_addr` / `req1_addr`  in  ADDR_W  write address.
- `req0_data` / `req1_data`  in  DATA_W  write data.
- `req0_ready` / `req1_ready`  out  1  grant; the write is accepted when valid&ready.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after the address.
- `steal_count`  out  16  saturating count of stolen display slots.

## Operation
- Each cycle has exactly one memory slot: a display READ, a WRITE to port 0 or 1, or IDLE.
- Slot selection, in priority order:
  - **STEAL.** If `starve_cnt == STARVE_LIMIT` and any writer is valid, the slot is a WRITE, even when `vga_valid` = 1.
  - **READ.** Else if `vga_valid` = 1: `mem_addr = vga_addr`, `mem_we = 0`, both readies 0.
  - **WRITE.** Else if any writer is valid, grant per round-robin: `mem_addr`/`mem_wdata` from the granted port, `mem_we = 1`, that port's ready = 1.
  - **IDLE.** Otherwise `mem_we = 0` and `mem_addr = vga_addr`.
- Round-robin:
  - 1-bit `rr_last` holds the last granted port.
  - When both writers are valid, the grant goes to `!rr_last`.
  - When one writer is valid, it is granted.
  - `rr_last` updates on every grant.
- `starve_cnt` (8 bit):
  - Increments when any writer is valid and none is granted.
  - Clears on any grant, and when no writer is valid.
  - Saturates at `STARVE_LIMIT`.
- `rd_pend`: registered flag, equal to 1 in the cycle after a READ slot.
  - `vga_data <= mem_rdata` when `rd_pend` = 1.
  - Otherwise `vga_data` holds its value. After a stolen slot, the previous pixel is therefore repeated.
- `steal_count` increments by 1 per STEAL grant and saturates at 0xFFFF.
- Slot decode (`mem_*`, `reqN_ready`) is combinational from inputs and state. No combinational path exists from `mem_rdata` to any output.
- Writers must hold addr/data stable while valid and not ready. The block accepts no write without ready.

## Timing
- Read latency: `vga_addr` in cycle N → `mem_rdata` in N+1 → `vga_data` visible in N+2. The constant 2-cycle latency is compensated by the VGA controller's pipeline.
- Write: accepted and committed in the same cycle as valid&ready; throughput is one write per non-read cycle.
- A STEAL lasts exactly one cycle. `starve_cnt` clears, so the next steal needs another `STARVE_LIMIT` blocked cycles.
- Both writers valid during blanking: they alternate 0,1,0,1…
- Reset (`resetn` = 0, asynchronous, honoured at any time including mid-write):
  - `vga_data` = 0, `steal_count` = 0, `starve_cnt` = 0, `rd_pend` = 0.
  - `rr_last` = 1, so port 0 gets the first grant.
  - While asserted: `mem_we` = 0, `req0_ready` = `req1_ready` = 0, `mem_addr` = `vga_addr`.
  - A read in flight at reset is discarded.
- Release: first slot decision in the first rising edge with `resetn` = 1.

## Test plan
- **Read pipeline.** Preload mem[0x00010] = 0x123456; `vga_valid` = 1, `vga_addr` = 0x00010 at cycle N → `vga_data` = 0x123456 at N+2; `mem_we` stays 0.
- **Round-robin.** `vga_valid` = 0; both writers valid with 4 writes each (port 0 data 0xAA0000+i, port 1 data 0x00BB00+i) → grants alternate 0,1,0,1… starting with port 0; all 8 addresses hold the correct data.
- **Steal.** `vga_valid` held 1; `req1_valid` = 1 from cycle 0 → `req1_ready` = 1 only at cycle 15; `steal_count` = 1; `vga_data` at cycle 17 equals the value from cycle 16 (repeated pixel).
- **Display protection.** With `vga_valid` = 1 and a writer valid for fewer than 15 cycles, then `vga_valid` = 0 → no ready during the active cycles; the write is granted in the first blanking cycle; `steal_count` unchanged.
- **Async reset.** Assert `resetn` = 0 mid-write during a steal-heavy run → `mem_we` = 0 and both readies = 0 immediately, before the next clock; `vga_data` = 0, `steal_count` = 0; after release port 0 wins the first contention.
- **Saturation.** Force 65,540 steals (`STARVE_LIMIT` = 1) → `steal_count` stops at 0xFFFF.

Source files
------------

// File: rtl/vmem_arbiter_if.sv
// vmem_arbiter_if: bus bundle for vmem_arbiter (VGA read port, writer ports 0/1, frame-buffer port, steal counter); slave = arbiter side, master = environment side
interface vmem_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
);
    logic              vga_valid;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       steal_count;
    modport slave (
        input  vga_valid, vga_addr, req0_valid, req0_addr, req0_data,
               req1_valid, req1_addr, req1_data, mem_rdata,
        output vga_data, req0_ready, req1_ready, mem_addr, mem_we, mem_wdata, steal_count
    );
    modport master (
        output vga_valid, vga_addr, req0_valid, req0_addr, req0_data,
               req1_valid, req1_addr, req1_data, mem_rdata,
        input  vga_data, req0_ready, req1_ready, mem_addr, mem_we, mem_wdata, steal_count
    );
endinterface

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: one-slot-per-cycle frame-buffer arbiter (display reads, round-robin writers, starvation steal); ports: clk, resetn (async active-low), bus (vmem_arbiter_if.slave)
module vmem_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 24,
    parameter int STARVE_LIMIT = 15
) (
    input  logic          clk,
    input  logic          resetn,
    vmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {SLOT_IDLE, SLOT_READ, SLOT_W0, SLOT_W1} slot_e;
    slot_e             slot;
    logic              any_req, steal, gnt1, wr;
    logic [ADDR_W-1:0] addr_c;
    logic              rr_last_q, rr_last_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    logic [15:0]       steal_count_q, steal_count_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    always_comb begin
        any_req        = bus.req0_valid | bus.req1_valid;
        steal          = any_req && starve_cnt_q == 8'(STARVE_LIMIT);
        gnt1           = (bus.req0_valid && bus.req1_valid) ? !rr_last_q : bus.req1_valid;
        slot           = !resetn ? SLOT_IDLE :
                         (steal || (any_req && !bus.vga_valid)) ? (gnt1 ? SLOT_W1 : SLOT_W0) :
                         bus.vga_valid ? SLOT_READ : SLOT_IDLE;
        wr             = slot == SLOT_W0 || slot == SLOT_W1;
        addr_c         = slot == SLOT_W0 ? bus.req0_addr : slot == SLOT_W1 ? bus.req1_addr : bus.vga_addr;
        bus.mem_addr   = addr_c;
        bus.mem_we     = wr;
        bus.mem_wdata  = slot == SLOT_W1 ? bus.req1_data : bus.req0_data;
        bus.req0_ready = slot == SLOT_W0;
        bus.req1_ready = slot == SLOT_W1;
        bus.vga_data   = vga_data_q;
        bus.steal_count = steal_count_q;
        rr_last_d      = wr ? slot == SLOT_W1 : rr_last_q;
        starve_cnt_d   = (wr || !any_req) ? 8'd0 :
                         starve_cnt_q == 8'(STARVE_LIMIT) ? starve_cnt_q : starve_cnt_q + 8'd1;
        rd_pend_d      = slot == SLOT_READ;
        // mem_rdata only reaches vga_data through this register, keeping it off every combinational output
        vga_data_d     = rd_pend_q ? bus.mem_rdata : vga_data_q;
        steal_count_d  = (steal && wr && steal_count_q != 16'hFFFF) ? steal_count_q + 16'd1 : steal_count_q;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_last_q     <= 1'b1;
            rd_pend_q     <= 1'b0;
            starve_cnt_q  <= '0;
            steal_count_q <= '0;
            vga_data_q    <= '0;
        end else begin
            rr_last_q     <= rr_last_d;
            rd_pend_q     <= rd_pend_d;
            starve_cnt_q  <= starve_cnt_d;
            steal_count_q <= steal_count_d;
            vga_data_q    <= vga_data_d;
        end
    end
endmodule

// File: tb/tb_vmem_arbiter.sv
// tb_vmem_arbiter: randomized and directed checks of vmem_arbiter against a cycle-level behavioural model
module tb_vmem_arbiter;
    localparam int LIMIT = 15;
    logic clk = 0, fclk = 0, resetn = 1, sresetn = 0;
    always #5 clk = ~clk;
    always #1 fclk = ~fclk;
    vmem_arbiter_if #(.ADDR_W(19), .DATA_W(24)) bus();
    vmem_arbiter_if #(.ADDR_W(19), .DATA_W(24)) sbus();
    vmem_arbiter #(.ADDR_W(19), .DATA_W(24), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
    vmem_arbiter #(.ADDR_W(19), .DATA_W(24), .STARVE_LIMIT(1)) sdut (.clk(fclk), .resetn(sresetn), .bus(sbus.slave));
    assign sbus.mem_rdata = '0;
    logic [23:0] fb [0:(1<<19)-1];
    always @(posedge clk) begin
        if (bus.mem_we) fb[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= fb[bus.mem_addr];
    end
    int n_tests = 0, n_fail = 0;
    int m_blk, m_steals;
    bit m_last, m_pend;
    logic [23:0] m_vga, m_pv;
    logic [23:0] mfb [int];
    function automatic logic [23:0] mget(int a);
        return mfb.exists(a) ? mfb[a] : 24'h0;
    endfunction
    function automatic bit exp_steal();
        return (bus.req0_valid || bus.req1_valid) && m_blk >= LIMIT;
    endfunction
    // 0 idle, 1 read, 2 write port 0, 3 write port 1
    function automatic int exp_slot();
        bit any = bus.req0_valid || bus.req1_valid;
        if (exp_steal() || (any && !bus.vga_valid))
            return (bus.req0_valid && bus.req1_valid) ? (m_last ? 2 : 3) : (bus.req0_valid ? 2 : 3);
        return bus.vga_valid ? 1 : 0;
    endfunction
    task automatic model_reset();
        m_blk = 0; m_steals = 0; m_last = 1; m_pend = 0; m_vga = 0;
    endtask
    task automatic tick();
        int k = exp_slot();
        bit s = exp_steal();
        bit any = bus.req0_valid || bus.req1_valid;
        if (!resetn) model_reset();
        else begin
            if (m_pend) m_vga = m_pv;
            m_pend = (k == 1);
            if (k == 1) m_pv = mget(int'(bus.vga_addr));
            if (k >= 2) begin
                mfb[int'(k == 2 ? bus.req0_addr : bus.req1_addr)] = (k == 2) ? bus.req0_data : bus.req1_data;
                m_last = (k == 3);
                m_blk = 0;
                if (s && m_steals < 65535) m_steals++;
            end else m_blk = any ? (m_blk < LIMIT ? m_blk + 1 : LIMIT) : 0;
        end
        @(posedge clk); #1;
    endtask
    task automatic set_idle();
        bus.vga_valid = 0; bus.vga_addr = '0;
        bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
    endtask
    task automatic do_reset();
        set_idle();
        resetn = 0;
        model_reset();
        @(posedge clk); #1;
        resetn = 1;
    endtask
    task automatic test_reset();
        set_idle();
        bus.vga_valid = 1; bus.vga_addr = 19'h1234;
        bus.req0_valid = 1; bus.req0_addr = 19'h11; bus.req0_data = 24'h111111;
        bus.req1_valid = 1; bus.req1_addr = 19'h22; bus.req1_data = 24'h222222;
        #1 resetn = 0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            #2;
            n_tests += 5;
            if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we c=%0d got=%b exp=0", c, bus.mem_we); end
            if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready c=%0d got=%b exp=00", c, {bus.req1_ready, bus.req0_ready}); end
            if (bus.mem_addr !== 19'h1234) begin n_fail++; $display("FAIL reset_addr c=%0d got=%h exp=1234", c, bus.mem_addr); end
            if (bus.vga_data !== 24'h0) begin n_fail++; $display("FAIL reset_vga c=%0d got=%h exp=0", c, bus.vga_data); end
            if (bus.steal_count !== 16'h0) begin n_fail++; $display("FAIL reset_steal c=%0d got=%h exp=0", c, bus.steal_count); end
            @(posedge clk); #1;
        end
        set_idle();
        resetn = 1;
    endtask
    task automatic test_read();
        do_reset();
        fb[19'h10] = 24'h123456; mfb[32'h10] = 24'h123456;
        bus.vga_valid = 1; bus.vga_addr = 19'h10;
        #2;
        n_tests += 2;
        if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL read_we got=%b exp=0", bus.mem_we); end
        if (bus.mem_addr !== 19'h10) begin n_fail++; $display("FAIL read_addr got=%h exp=10", bus.mem_addr); end
        tick();
        bus.vga_valid = 0; bus.vga_addr = 19'h0;
        #2;
        n_tests++;
        if (bus.vga_data !== 24'h0) begin n_fail++; $display("FAIL read_early got=%h exp=0", bus.vga_data); end
        tick();
        #2;
        n_tests++;
        if (bus.vga_data !== 24'h123456) begin n_fail++; $display("FAIL read_data got=%h exp=123456", bus.vga_data); end
    endtask
    task automatic test_round_robin();
        int i0 = 0, i1 = 0;
        bit r0, r1;
        do_reset();
        for (int g = 0; g < 8; g++) begin
            bus.req0_valid = i0 < 4; bus.req0_addr = 19'(32'h100 + i0); bus.req0_data = 24'(32'hAA0000 + i0);
            bus.req1_valid = i1 < 4; bus.req1_addr = 19'(32'h200 + i1); bus.req1_data = 24'(32'h00BB00 + i1);
            #2;
            n_tests += 2;
            if ({bus.req1_ready, bus.req0_ready} !== {g[0], ~g[0]}) begin n_fail++; $display("FAIL rr_grant g=%0d got=%b exp=%b", g, {bus.req1_ready, bus.req0_ready}, {g[0], ~g[0]}); end
            if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rr_we g=%0d got=%b exp=1", g, bus.mem_we); end
            r0 = bus.req0_ready; r1 = bus.req1_ready;
            tick();
            if (r0) i0++;
            if (r1) i1++;
        end
        set_idle();
        tick();
        for (int i = 0; i < 4; i++) begin
            n_tests += 2;
            if (fb[19'(32'h100 + i)] !== 24'(32'hAA0000 + i)) begin n_fail++; $display("FAIL rr_mem0 i=%0d got=%h exp=%h", i, fb[19'(32'h100 + i)], 24'(32'hAA0000 + i)); end
            if (fb[19'(32'h200 + i)] !== 24'(32'h00BB00 + i)) begin n_fail++; $display("FAIL rr_mem1 i=%0d got=%h exp=%h", i, fb[19'(32'h200 + i)], 24'(32'h00BB00 + i)); end
        end
    endtask
    task automatic test_steal();
        logic [23:0] v16;
        bit r;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            fb[19'(32'h300 + c)] = 24'(32'h100000 + c * 32'h111);
            mfb[32'h300 + c] = 24'(32'h100000 + c * 32'h111);
        end
        bus.vga_valid = 1;
        bus.req1_valid = 1; bus.req1_addr = 19'h50; bus.req1_data = 24'hC0FFEE;
        v16 = '0;
        for (int c = 0; c < 18; c++) begin
            bus.vga_addr = 19'(32'h300 + c);
            #2;
            n_tests += 3;
            if (bus.req1_ready !== (c == 15)) begin n_fail++; $display("FAIL steal_ready c=%0d got=%b exp=%b", c, bus.req1_ready, c == 15); end
            if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL steal_ready0 c=%0d got=%b exp=0", c, bus.req0_ready); end
            if (bus.vga_data !== m_vga) begin n_fail++; $display("FAIL steal_vga c=%0d got=%h exp=%h", c, bus.vga_data, m_vga); end
            if (c == 16) begin
                n_tests++;
                if (bus.steal_count !== 16'd1) begin n_fail++; $display("FAIL steal_count got=%0d exp=1", bus.steal_count); end
                v16 = bus.vga_data;
            end
            if (c == 17) begin
                n_tests++;
                if (bus.vga_data !== 24'(32'h100000 + 14 * 32'h111) || bus.vga_data !== v16) begin n_fail++; $display("FAIL steal_repeat got=%h exp=%h", bus.vga_data, 24'(32'h100000 + 14 * 32'h111)); end
            end
            r = bus.req1_ready;
            tick();
            if (r) bus.req1_valid = 0;
        end
        n_tests++;
        if (fb[19'h50] !== 24'hC0FFEE) begin n_fail++; $display("FAIL steal_mem got=%h exp=c0ffee", fb[19'h50]); end
    endtask
    task automatic test_protect();
        do_reset();
        bus.vga_valid = 1; bus.vga_addr = 19'h7;
        bus.req0_valid = 1; bus.req0_addr = 19'h60; bus.req0_data = 24'h0D0D0D;
        for (int c = 0; c < 10; c++) begin
            #2;
            n_tests++;
            if ({bus.mem_we, bus.req1_ready, bus.req0_ready} !== 3'b000) begin n_fail++; $display("FAIL prot_active c=%0d got=%b exp=000", c, {bus.mem_we, bus.req1_ready, bus.req0_ready}); end
            tick();
        end
        bus.vga_valid = 0;
        #2;
        n_tests++;
        if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL prot_blank got=%b exp=1", bus.req0_ready); end
        tick();
        set_idle();
        #2;
        n_tests += 2;
        if (bus.steal_count !== 16'd0) begin n_fail++; $display("FAIL prot_steal got=%0d exp=0", bus.steal_count); end
        if (fb[19'h60] !== 24'h0D0D0D) begin n_fail++; $display("FAIL prot_mem got=%h exp=0d0d0d", fb[19'h60]); end
    endtask
    task automatic test_async_reset();
        int nst = 0;
        bit found = 0, r;
        do_reset();
        bus.vga_valid = 1; bus.vga_addr = 19'h33;
        bus.req0_valid = 1; bus.req0_addr = 19'h70; bus.req0_data = 24'hABCDEF;
        bus.req1_valid = 1; bus.req1_addr = 19'h71; bus.req1_data = 24'hFEDCBA;
        for (int c = 0; c < 100 && !found; c++) begin
            #2;
            if (bus.mem_we && nst == 2) found = 1;
            else begin
                r = bus.mem_we;
                tick();
                if (r) nst++;
            end
        end
        n_tests += 2;
        if (!found) begin n_fail++; $display("FAIL ar_third_steal got=none exp=found"); end
        if (bus.steal_count !== 16'd2) begin n_fail++; $display("FAIL ar_pre_count got=%0d exp=2", bus.steal_count); end
        resetn = 0;
        #1;
        n_tests += 5;
        if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL ar_we got=%b exp=0", bus.mem_we); end
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL ar_ready got=%b exp=00", {bus.req1_ready, bus.req0_ready}); end
        if (bus.mem_addr !== 19'h33) begin n_fail++; $display("FAIL ar_addr got=%h exp=33", bus.mem_addr); end
        if (bus.vga_data !== 24'h0) begin n_fail++; $display("FAIL ar_vga got=%h exp=0", bus.vga_data); end
        if (bus.steal_count !== 16'h0) begin n_fail++; $display("FAIL ar_count got=%0d exp=0", bus.steal_count); end
        model_reset();
        @(posedge clk); #1;
        resetn = 1;
        bus.vga_valid = 0;
        #2;
        n_tests++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL ar_first_grant got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
        tick();
        set_idle();
    endtask
    task automatic test_random();
        int k;
        bit r0, r1, ew;
        logic [18:0] ea;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.vga_valid = $urandom_range(0, 19) != 0;
            bus.vga_addr = 19'($urandom_range(0, 255));
            #2;
            k = exp_slot();
            ew = k >= 2;
            ea = k == 2 ? bus.req0_addr : k == 3 ? bus.req1_addr : bus.vga_addr;
            n_tests += 5;
            if (bus.mem_we !== ew) begin n_fail++; $display("FAIL rand_we c=%0d got=%b exp=%b", c, bus.mem_we, ew); end
            if (bus.mem_addr !== ea) begin n_fail++; $display("FAIL rand_addr c=%0d got=%h exp=%h", c, bus.mem_addr, ea); end
            if ({bus.req1_ready, bus.req0_ready} !== {k == 3, k == 2}) begin n_fail++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, {bus.req1_ready, bus.req0_ready}, {k == 3, k == 2}); end
            if (bus.vga_data !== m_vga) begin n_fail++; $display("FAIL rand_vga c=%0d got=%h exp=%h", c, bus.vga_data, m_vga); end
            if (bus.steal_count !== 16'(m_steals)) begin n_fail++; $display("FAIL rand_steal c=%0d got=%0d exp=%0d", c, bus.steal_count, m_steals); end
            if (ew) begin
                n_tests++;
                if (bus.mem_wdata !== (k == 3 ? bus.req1_data : bus.req0_data)) begin n_fail++; $display("FAIL rand_wdata c=%0d got=%h exp=%h", c, bus.mem_wdata, k == 3 ? bus.req1_data : bus.req0_data); end
            end
            r0 = bus.req0_ready; r1 = bus.req1_ready;
            tick();
            if (r0 || !bus.req0_valid) begin
                bus.req0_valid = $urandom_range(0, 3) != 0;
                bus.req0_addr = 19'($urandom_range(0, 255)); bus.req0_data = 24'($urandom());
            end
            if (r1 || !bus.req1_valid) begin
                bus.req1_valid = $urandom_range(0, 3) != 0;
                bus.req1_addr = 19'($urandom_range(0, 255)); bus.req1_data = 24'($urandom());
            end
        end
        set_idle();
    endtask
    task automatic test_saturation();
        int n = 0;
        sbus.vga_valid = 1; sbus.vga_addr = '0;
        sbus.req0_valid = 1; sbus.req0_addr = 19'h5; sbus.req0_data = 24'h5;
        sbus.req1_valid = 0; sbus.req1_addr = '0; sbus.req1_data = '0;
        @(negedge fclk);
        sresetn = 1;
        for (int c = 0; c < 135000 && n < 65540; c++) begin
            @(negedge fclk);
            if (sbus.req0_ready) begin
                n++;
                if (n == 1000) begin
                    n_tests++;
                    if (sbus.steal_count !== 16'd999) begin n_fail++; $display("FAIL sat_mid got=%0d exp=999", sbus.steal_count); end
                end
            end
        end
        @(negedge fclk);
        n_tests += 2;
        if (n != 65540) begin n_fail++; $display("FAIL sat_steals got=%0d exp=65540", n); end
        if (sbus.steal_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count got=%h exp=ffff", sbus.steal_count); end
    endtask
    initial begin
        sbus.vga_valid = 0; sbus.vga_addr = '0;
        sbus.req0_valid = 0; sbus.req0_addr = '0; sbus.req0_data = '0;
        sbus.req1_valid = 0; sbus.req1_addr = '0; sbus.req1_data = '0;
        test_reset();
        test_read();
        test_round_robin();
        test_steal();
        test_protect();
        test_async_reset();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
